gonso_wb_master: RTL

Wishbone classic single-transfer initiator for the user area. It accepts one read or write command at a time on a valid/ready command port and runs exactly one Wishbone cycle. It returns the read data, or a timeout error, on a valid/ready response port. Used as the on-chip driver for register-mapped responders such as the gonso register bank (e.g. 0x30030004/08/0C), and as the bus-side engine of later sequencers.

---
 rtl/gonso_wb_master.sv | 133 +++++++++++++
 1 files changed

// File: rtl/gonso_wb_master.sv
// rtl/gonso_wb_master.sv - Wishbone classic single-transfer initiator with ack timeout
module gonso_wb_master #(
  parameter int TWIDTH  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [TWIDTH-1:0] TLAST = TWIDTH'(TIMEOUT - 1);

  state_t            state, state_n;
  logic [TWIDTH-1:0] cnt, cnt_n;
  logic              cmd_ready_n, rsp_valid_n, rsp_err_n;
  logic [31:0]       rsp_rdata_n;
  logic              cyc_n, stb_n, we_n;
  logic [31:0]       adr_n, dat_n;
  logic [3:0]        sel_n;
  logic              busy_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
      wbm_cyc_o <= cyc_n;
      wbm_stb_o <= stb_n;
      wbm_we_o  <= we_n;
      wbm_adr_o <= adr_n;
      wbm_dat_o <= dat_n;
      wbm_sel_o <= sel_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cmd_ready_n = cmd_ready;
    rsp_valid_n = rsp_valid;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    cyc_n       = wbm_cyc_o;
    stb_n       = wbm_stb_o;
    we_n        = wbm_we_o;
    adr_n       = wbm_adr_o;
    dat_n       = wbm_dat_o;
    sel_n       = wbm_sel_o;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          we_n        = cmd_we;
          adr_n       = cmd_addr;
          dat_n       = cmd_wdata;
          sel_n       = cmd_sel;
          cyc_n       = 1'b1;
          stb_n       = 1'b1;
          cnt_n       = '0;
          cmd_ready_n = 1'b0;
          state_n     = BUS;
        end
      end
      BUS: begin
        // Ack is checked first so a same-edge ack beats the timeout.
        if (wbm_ack_i) begin
          cyc_n       = 1'b0;
          stb_n       = 1'b0;
          rsp_rdata_n = wbm_we_o ? 32'h0 : wbm_dat_i;
          rsp_err_n   = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end else if (cnt == TLAST) begin
          cyc_n       = 1'b0;
          stb_n       = 1'b0;
          rsp_rdata_n = 32'h0;
          rsp_err_n   = 1'b1;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule
